// File: rtl/freq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | freq_pkg                                                                   |
// | Shared state encoding and default constants for the frequency reader.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package freq_pkg;

  localparam int FREQ_WORD_W      = 32;
  localparam int FREQ_RST_CYCLES  = 4;
  localparam int FREQ_HALF_PERIOD = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    LOW  = 3'd2,
    HIGH = 3'd3,
    HOLD = 3'd4
  } freqState_t;

endpackage
`default_nettype wire

// File: rtl/freq_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | freq_phase_timer                                                           |
// | Loadable down-counter; done is high during the last cycle of a phase.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module freq_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  // A phase loaded with N lasts N cycles: the count walks N..1, done on 1.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= loadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/freq_shift_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | freq_shift_reader                                                          |
// | Captures the counter stage and shifts its word in LSB first.               |
// | Optional macro FREQ_READER_AUTO_EN adds a periodic internal trigger.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module freq_shift_reader
  import freq_pkg::*;
#(
  parameter int WORD_W        = FREQ_WORD_W,
  parameter int RST_CYCLES    = FREQ_RST_CYCLES,
  parameter int HALF_PERIOD   = FREQ_HALF_PERIOD,
  parameter int AUTO_INTERVAL = 40000000
) (
  input  logic              CLOCK,
  input  logic              reset,
  input  logic              start,
  input  logic              valueIn,
  output logic              shiftRst,
  output logic              shiftClk,
  output logic [WORD_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy
);

  localparam int c_idxW     = $clog2(WORD_W);
  localparam int c_timerMax = (RST_CYCLES > HALF_PERIOD) ? RST_CYCLES : HALF_PERIOD;
  localparam int c_timerW   = $clog2(c_timerMax + 1);

  localparam logic [c_idxW-1:0]   c_lastIdx  = c_idxW'(WORD_W - 1);
  localparam logic [c_timerW-1:0] c_rstLoad  = c_timerW'(RST_CYCLES);
  localparam logic [c_timerW-1:0] c_halfLoad = c_timerW'(HALF_PERIOD);

  freqState_t          r_state;
  logic [c_idxW-1:0]   r_bitIdx;
  logic                w_trigger;
  logic                w_phaseDone;
  logic                w_timerLoad;
  logic [c_timerW-1:0] w_timerValue;

`ifdef FREQ_READER_AUTO_EN
  localparam int c_autoW = (AUTO_INTERVAL > 1) ? $clog2(AUTO_INTERVAL) : 1;
  localparam logic [c_autoW-1:0] c_autoLast = c_autoW'(AUTO_INTERVAL - 1);

  logic [c_autoW-1:0] r_autoCnt;
  logic               w_autoPulse;

  // Free-running; a pulse landing outside IDLE is simply lost.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_autoCnt <= '0;
    end else if (w_autoPulse) begin
      r_autoCnt <= '0;
    end else begin
      r_autoCnt <= r_autoCnt + 1'b1;
    end
  end

  assign w_autoPulse = (r_autoCnt == c_autoLast);
  assign w_trigger   = start | w_autoPulse;
`else
  logic w_unusedAuto;
  assign w_unusedAuto = (AUTO_INTERVAL != 0);
  assign w_trigger    = start;
`endif

  freq_phase_timer #(
    .WIDTH (c_timerW)
  ) u_phaseTimer (
    .CLOCK     (CLOCK),
    .reset     (reset),
    .load      (w_timerLoad),
    .loadValue (w_timerValue),
    .done      (w_phaseDone)
  );

  // Reload on every phase entry; nothing is loaded when heading into HOLD.
  always_comb begin
    w_timerLoad  = 1'b0;
    w_timerValue = c_halfLoad;
    case (r_state)
      IDLE: begin
        w_timerLoad  = w_trigger;
        w_timerValue = c_rstLoad;
      end
      RST, HIGH: w_timerLoad = w_phaseDone;
      LOW:       w_timerLoad = w_phaseDone && (r_bitIdx != c_lastIdx);
      default:   w_timerLoad = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bitIdx   <= '0;
      shiftRst   <= 1'b0;
      shiftClk   <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_state  <= RST;
            shiftRst <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RST: begin
          if (w_phaseDone) begin
            r_state  <= LOW;
            shiftRst <= 1'b0;
            r_bitIdx <= '0;
          end
        end
        LOW: begin
          if (w_phaseDone) begin
            data[r_bitIdx] <= valueIn;
            if (r_bitIdx == c_lastIdx) begin
              r_state    <= HOLD;
              data_valid <= 1'b1;
            end else begin
              r_state  <= HIGH;
              shiftClk <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (w_phaseDone) begin
            r_state  <= LOW;
            shiftClk <= 1'b0;
            r_bitIdx <= r_bitIdx + 1'b1;
          end
        end
        HOLD: begin
          if (data_ready) begin
            r_state    <= IDLE;
            data_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_shift_reader.sv
`default_nettype none
// Directed bench: a 32-bit shift-register model of the counter stage drives valueIn.
module tb_freq_shift_reader;

  logic        CLOCK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        data_ready = 1'b0;
  logic        valueIn;
  logic        shiftRst;
  logic        shiftClk;
  logic [31:0] data;
  logic        data_valid;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] modelValue = 32'h0;
  logic [31:0] shReg      = 32'h0;
  logic [4:0]  shIdx      = 5'd0;
  logic        prevRst    = 1'b0;
  logic        prevClk    = 1'b0;
  int          clkRises   = 0;
  int          rstCycles  = 0;

  always #5 CLOCK = ~CLOCK;

  assign valueIn = shReg[shIdx];

  freq_shift_reader #(
    .WORD_W        (32),
    .RST_CYCLES    (4),
    .HALF_PERIOD   (4),
    .AUTO_INTERVAL (1000)
  ) dut (
    .CLOCK      (CLOCK),
    .reset      (reset),
    .start      (start),
    .valueIn    (valueIn),
    .shiftRst   (shiftRst),
    .shiftClk   (shiftClk),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy)
  );

  // Counter-stage model: load on shiftRst rise, advance on shiftClk rise.
  always @(posedge CLOCK) begin
    prevRst <= shiftRst;
    prevClk <= shiftClk;
    if (shiftRst) rstCycles <= rstCycles + 1;
    if (shiftRst && !prevRst) begin
      shReg <= modelValue;
      shIdx <= 5'd0;
    end else if (shiftClk && !prevClk) begin
      shIdx    <= shIdx + 5'd1;
      clkRises <= clkRises + 1;
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge CLOCK);
    #1;
    compared++; if (shiftRst !== 1'b0) begin mismatched++; $display("FAIL reset_shiftRst: got %b expected 0", shiftRst); end
    compared++; if (shiftClk !== 1'b0) begin mismatched++; $display("FAIL reset_shiftClk: got %b expected 0", shiftClk); end
    compared++; if (data !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h expected 00000000", data); end
    compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge CLOCK) reset = 1'b0;
  endtask

`ifndef FREQ_READER_AUTO_EN
  task automatic test_read_basic();
    int lat, rises0, rst0;
    modelValue = 32'hDEADBEEF;
    rises0 = clkRises;
    rst0   = rstCycles;
    @(negedge CLOCK) start = 1'b1;
    @(posedge CLOCK);
    #1 start = 1'b0;
    lat = 1;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL accept_busy: got %b expected 1", busy); end
    compared++; if (shiftRst !== 1'b1) begin mismatched++; $display("FAIL accept_shiftRst: got %b expected 1", shiftRst); end
    while (data_valid !== 1'b1 && lat < 400) begin
      @(posedge CLOCK);
      #1 lat++;
    end
    compared++; if (lat != 257) begin mismatched++; $display("FAIL basic_latency: got %0d expected 257", lat); end
    compared++; if (data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL basic_data: got %h expected deadbeef", data); end
    compared++; if (clkRises - rises0 != 31) begin mismatched++; $display("FAIL basic_clk_rises: got %0d expected 31", clkRises - rises0); end
    compared++; if (rstCycles - rst0 != 4) begin mismatched++; $display("FAIL basic_rst_cycles: got %0d expected 4", rstCycles - rst0); end
  endtask

  task automatic test_hold_stall();
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLOCK);
      #1;
      start = (i == 50);
      if (data !== 32'hDEADBEEF || busy !== 1'b1 || data_valid !== 1'b1) bad++;
    end
    start = 1'b0;
    compared++; if (bad != 0) begin mismatched++; $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); end
    data_ready = 1'b1;
    @(posedge CLOCK);
    #1 data_ready = 1'b0;
    compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL handshake_valid: got %b expected 0", data_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL handshake_busy: got %b expected 0", busy); end
    repeat (5) @(posedge CLOCK);
    #1;
    compared++; if ({busy, shiftRst} !== 2'b00) begin mismatched++; $display("FAIL start_not_queued: got %b expected 00", {busy, shiftRst}); end
  endtask

  task automatic test_reset_midread();
    int n, rises0, rst0;
    modelValue = 32'h12345678;
    @(negedge CLOCK) start = 1'b1;
    @(negedge CLOCK) start = 1'b0;
    n = 0;
    while (shIdx != 5'd10 && n < 400) begin
      @(posedge CLOCK);
      #1 n++;
    end
    compared++; if (shIdx != 5'd10) begin mismatched++; $display("FAIL midread_reach_bit10: got %0d expected 10", shIdx); end
    @(negedge CLOCK) reset = 1'b1;
    #1;
    compared++; if ({shiftRst, shiftClk, data_valid, busy} !== 4'b0000) begin mismatched++; $display("FAIL midread_reset_ctrl: got %b expected 0000", {shiftRst, shiftClk, data_valid, busy}); end
    compared++; if (data !== 32'h0) begin mismatched++; $display("FAIL midread_reset_data: got %h expected 00000000", data); end
    @(negedge CLOCK) reset = 1'b0;
    modelValue = 32'h00000001;
    rises0 = clkRises;
    rst0   = rstCycles;
    @(negedge CLOCK) start = 1'b1;
    @(negedge CLOCK) start = 1'b0;
    n = 0;
    while (data_valid !== 1'b1 && n < 400) begin
      @(posedge CLOCK);
      #1 n++;
    end
    compared++; if (data !== 32'h00000001) begin mismatched++; $display("FAIL fresh_data: got %h expected 00000001", data); end
    compared++; if (rstCycles - rst0 != 4) begin mismatched++; $display("FAIL fresh_rst_cycles: got %0d expected 4", rstCycles - rst0); end
    compared++; if (clkRises - rises0 != 31) begin mismatched++; $display("FAIL fresh_clk_rises: got %0d expected 31", clkRises - rises0); end
    data_ready = 1'b1;
    @(posedge CLOCK);
    #1 data_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    modelValue = 32'h0;
    @(negedge CLOCK);
    start      = 1'b1;
    data_ready = 1'b1;
    n = 0;
    while (data_valid !== 1'b1 && n < 400) begin
      @(posedge CLOCK);
      #1 n++;
    end
    compared++; if (data !== 32'h0 || data_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_first: got %h/%b expected 00000000/1", data, data_valid); end
    @(posedge CLOCK);
    #1;
    compared++; if ({busy, data_valid} !== 2'b00) begin mismatched++; $display("FAIL b2b_idle_gap: got %b expected 00", {busy, data_valid}); end
    modelValue = 32'hFFFFFFFF;
    @(posedge CLOCK);
    #1;
    compared++; if ({busy, shiftRst} !== 2'b11) begin mismatched++; $display("FAIL b2b_retrigger: got %b expected 11", {busy, shiftRst}); end
    start = 1'b0;
    n = 0;
    while (data_valid !== 1'b1 && n < 400) begin
      @(posedge CLOCK);
      #1 n++;
    end
    compared++; if (data !== 32'hFFFFFFFF || data_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_second: got %h/%b expected ffffffff/1", data, data_valid); end
    @(posedge CLOCK);
    #1 data_ready = 1'b0;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_end_idle: got %b expected 0", busy); end
  endtask

  task automatic test_no_auto();
    int active;
    active = 0;
    repeat (2500) begin
      @(posedge CLOCK);
      #1;
      if (busy || shiftRst || data_valid) active++;
    end
    compared++; if (active != 0) begin mismatched++; $display("FAIL no_auto_activity: got %0d active cycles expected 0", active); end
  endtask
`else
  task automatic test_auto();
    int t[3];
    int n, k;
    logic pv;
    t = '{0, 0, 0};
    data_ready = 1'b1;
    pv = data_valid;
    n = 0;
    k = 0;
    while (k < 3 && n < 4000) begin
      @(posedge CLOCK);
      #1 n++;
      if (data_valid && !pv) begin
        t[k] = n;
        k++;
      end
      pv = data_valid;
    end
    compared++; if (k != 3) begin mismatched++; $display("FAIL auto_pulses: got %0d expected 3", k); end
    compared++; if (t[1] - t[0] != 1000) begin mismatched++; $display("FAIL auto_interval1: got %0d expected 1000", t[1] - t[0]); end
    compared++; if (t[2] - t[1] != 1000) begin mismatched++; $display("FAIL auto_interval2: got %0d expected 1000", t[2] - t[1]); end
    data_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef FREQ_READER_AUTO_EN
    test_auto();
`else
    test_read_basic();
    test_hold_stall();
    test_reset_midread();
    test_back_to_back();
    test_no_auto();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_shift_reader.md
FREQ_SHIFT_READER -- requirements
Module: freq_shift_reader

Interface
REQ-001 SHALL have parameter WORD_W, default 32: bits read per capture; matches the counter's shift-register width.
REQ-002 SHALL have parameter RST_CYCLES, default 4: CLOCK cycles for which shiftRst is held high.
REQ-003 SHALL have parameter HALF_PERIOD, default 4: CLOCK cycles per shiftClk low or high phase; legal range is at least 2.
REQ-004 SHALL have parameter AUTO_INTERVAL, default 40000000: CLOCK cycles between auto-triggers (used only under FREQ_READER_AUTO_EN).
REQ-005 SHALL have port CLOCK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request one capture-and-read; sampled only in IDLE.
REQ-008 SHALL have port valueIn, input, 1 bit: serial bit from the counter stage, LSB first.
REQ-009 SHALL have port shiftRst, output, 1 bit: capture/rewind strobe to the counter stage.
REQ-010 SHALL have port shiftClk, output, 1 bit: bit-advance clock to the counter stage.
REQ-011 SHALL have port data, output, WORD_W bits: the assembled count.
REQ-012 SHALL have port data_valid, output, 1 bit: data holds a complete word.
REQ-013 SHALL have port data_ready, input, 1 bit: consumer accepts the word.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, RST, LOW, HIGH and HOLD.
REQ-016 IDLE SHALL go to RST when start=1; shiftRst SHALL be high for exactly RST_CYCLES cycles, beginning the cycle after start is accepted.
REQ-017 RST SHALL go to LOW with bit index 0; shiftClk SHALL be low for HALF_PERIOD cycles, and valueIn SHALL be sampled into data[index] on the last LOW cycle.
REQ-018 After LOW, if index < WORD_W-1 the block SHALL enter HIGH (shiftClk high for HALF_PERIOD cycles), then increment index and return to LOW; otherwise it SHALL enter HOLD.
REQ-019 With default parameters, data_valid SHALL rise exactly 4 + 63*4 + 1 = 257 cycles after the start-accept edge.
REQ-020 No shiftClk pulse SHALL follow the final bit; exactly WORD_W-1 rising edges SHALL be issued per read.
REQ-021 In HOLD, data_valid SHALL be 1 and data stable; when data_valid and data_ready are both 1 in a cycle, the block SHALL go to IDLE and drop data_valid on the next cycle.
REQ-022 start SHALL be ignored outside IDLE; there is no queueing.
REQ-023 start held continuously SHALL re-trigger one cycle after each handshake.
REQ-024 data SHALL be updated bit-in-place during LOW phases only; its value while data_valid=0 is don't-care.
REQ-025 The bit index SHALL be $clog2(WORD_W) bits wide, with no wrap inside one read.

Reset
REQ-026 On reset=1, regardless of state: state=IDLE, shiftRst=0, shiftClk=0, data=0, data_valid=0, busy=0, index=0, and all timers=0.
REQ-027 Reset asserted mid-read SHALL abandon the read; the next start SHALL perform a full fresh sequence, starting with shiftRst.

Configuration
REQ-028 With FREQ_READER_AUTO_EN defined, an internal counter SHALL raise an internal start pulse every AUTO_INTERVAL cycles, ORed with the start port; a pulse arriving outside IDLE SHALL be dropped, not deferred.
REQ-029 Without FREQ_READER_AUTO_EN, the counter and AUTO_INTERVAL SHALL be unused and synthesise away, and only the start port triggers reads.

Structure
REQ-030 A shared package freq_pkg SHALL hold the state enum, FREQ_WORD_W=32, and the default RST_CYCLES and HALF_PERIOD constants.
REQ-031 One sub-module, freq_phase_timer (a loadable down-counter with a done pulse), SHALL time the RST, LOW and HIGH phases; the FSM and shift register SHALL stay in freq_shift_reader.

Verification
REQ-032 Bench model: a 32-bit register loaded on shiftRst rise, with an index cleared by shiftRst and incremented on shiftClk rise.
REQ-033 Loaded 0xDEADBEEF, start pulse -> data=0xDEADBEEF, data_valid high 257 cycles after accept, with 31 shiftClk rising edges counted.
REQ-034 data_ready held 0 for 100 cycles after valid -> data stable and busy=1; a second start is ignored; ready=1 -> IDLE next cycle.
REQ-035 Reset asserted at bit 10 -> all outputs 0 within the same cycle; a new start reads 0x00000001 correctly.
REQ-036 start and data_ready held at 1 -> back-to-back reads with one IDLE cycle between them; the model value changed between reads (0x0, then 0xFFFFFFFF) is reflected.
REQ-037 FREQ_READER_AUTO_EN with AUTO_INTERVAL=1000 and data_ready=1 -> data_valid pulses every 1000 cycles with no start input; with the macro undefined -> no activity.
